ram_sync_param: RTL

- Parametrised synchronous single-port RAM. It is the next generation of the team's 4096x4 asynchronous RAM with a tri-state data bus.
- Replaces the bidirectional bus with separate write and read buses.
- Adds a registered read with configurable latency, a read-valid strobe, and a hardware clear engine that zero-fills the array after reset or on request.
- Sits as the general data/scratch memory behind the CPU/bus interface.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_sync_core.sv | 33 +++
 rtl/ram_sync_param.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the synchronous parametrised RAM.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_sync_core.sv
// Bare storage array: one synchronous write port and one registered read port.
module ram_sync_core
  import ram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sync_param.sv
// Synchronous single-port RAM with clear engine and 1- or 2-cycle read latency.
// Define RAM_PARITY_EN to store an even-parity bit per word and add the perr output.
module ram_sync_param
  import ram_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
`ifdef RAM_PARITY_EN
  ,
  output logic              perr
`endif
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CNT_W = ADDR_W + 1;
`ifdef RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  generate
    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
      $fatal(1, "ram_sync_param: READ_LAT must be 1 or 2");
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_busy;
  logic                w_mem_we;
  logic                w_mem_re;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [WORD_W-1:0]   w_mem_wdata;
  logic [WORD_W-1:0]   w_user_word;
  logic [WORD_W-1:0]   w_core_q;
  logic                r_rv1;

`ifdef RAM_PARITY_EN
  assign w_user_word = {^wdata, wdata};
`else
  assign w_user_word = wdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_busy       = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    w_mem_addr   = addr;
    w_mem_wdata  = w_user_word;
    case (r_state)
      ST_CLEAR: begin
        // Sweep owns the port; zero word also carries parity 0.
        w_busy      = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_cnt[ADDR_W-1:0];
        w_mem_wdata = '0;
        w_cnt_next  = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(DEPTH - 1)) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_mem_we = cs & we;
        w_mem_re = cs & ~we;
        if (clear) begin
          w_state_next = ST_CLEAR;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign busy = w_busy;

  ram_sync_core #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_core (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_core_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rv1 <= 1'b0;
    end else begin
      r_rv1 <= w_mem_re;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_rv2;
      logic [DATA_W-1:0] r_rdata2;
`ifdef RAM_PARITY_EN
      logic              r_perr2;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rv2    <= 1'b0;
          r_rdata2 <= '0;
`ifdef RAM_PARITY_EN
          r_perr2  <= 1'b0;
`endif
        end else begin
          r_rv2 <= r_rv1;
          if (r_rv1) begin
            r_rdata2 <= w_core_q[DATA_W-1:0];
`ifdef RAM_PARITY_EN
            r_perr2  <= w_core_q[DATA_W] ^ (^w_core_q[DATA_W-1:0]);
`endif
          end
        end
      end
      assign rdata  = r_rdata2;
      assign rvalid = r_rv2;
`ifdef RAM_PARITY_EN
      assign perr   = r_perr2;
`endif
    end else begin : g_lat1
      // Core read register is unreset; mask it until the first read after reset.
      logic r_seen;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_seen <= 1'b0;
        end else if (w_mem_re) begin
          r_seen <= 1'b1;
        end
      end
      assign rdata  = r_seen ? w_core_q[DATA_W-1:0] : '0;
      assign rvalid = r_rv1;
`ifdef RAM_PARITY_EN
      assign perr   = r_seen & (w_core_q[DATA_W] ^ (^w_core_q[DATA_W-1:0]));
`endif
    end
  endgenerate

endmodule
